sign_ext_arbiter: RTL and testbench

//   Shares one sign-extension unit between two immediate requesters (e.g. two

---
 rtl/sign_ext_arbiter.sv | 97 +++++++++
 tb/tb_sign_ext_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sign_ext_arbiter.sv
// Round-robin share of one sign-extension unit between two immediate requesters.
// The result sits in a registered output slot with a valid/ready handshake.

module sign_ext_beh #(
    parameter int N = 12,
    parameter int M = 32
) (
    input  logic [N-1:0] imm,
    output logic [M-1:0] ext
);

    assign ext = {{(M-N){imm[N-1]}}, imm};

endmodule

module sign_ext_arbiter #(
    parameter int N = 12,
    parameter int M = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_vld,
    input  logic [N-1:0] i_req0_imm,
    output logic         o_req0_rdy,
    input  logic         i_req1_vld,
    input  logic [N-1:0] i_req1_imm,
    output logic         o_req1_rdy,
    output logic         o_out_vld,
    output logic [M-1:0] o_out_imm,
    output logic         o_out_src,
    input  logic         i_out_rdy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t  slot_state;
    logic         prio;
    logic         can_load;
    logic         grant_any;
    logic         grant_id;
    logic         xfer;
    logic [N-1:0] mux_imm;
    logic [M-1:0] ext_imm;

    // A FULL slot can only take a new result on the edge its old one drains.
    assign can_load = (slot_state == EMPTY) | i_out_rdy;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (can_load) begin
            if (i_req0_vld && i_req1_vld) begin
                grant_any = 1'b1;
                grant_id  = prio;
            end else if (i_req0_vld) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (i_req1_vld) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign xfer       = grant_any;
    assign o_req0_rdy = !i_rst && grant_any && (grant_id == 1'b0);
    assign o_req1_rdy = !i_rst && grant_any && (grant_id == 1'b1);
    assign mux_imm    = grant_id ? i_req1_imm : i_req0_imm;

    sign_ext_beh #(
        .N(N),
        .M(M)
    ) u_ext (
        .imm(mux_imm),
        .ext(ext_imm)
    );

    // Priority flips to the loser only on an actual transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_state <= EMPTY;
            o_out_imm  <= '0;
            o_out_src  <= 1'b0;
            prio       <= 1'b0;
        end else if (xfer) begin
            slot_state <= FULL;
            o_out_imm  <= ext_imm;
            o_out_src  <= grant_id;
            prio       <= ~grant_id;
        end else if (slot_state == FULL && i_out_rdy) begin
            slot_state <= EMPTY;
        end
    end

    assign o_out_vld = (slot_state == FULL);

endmodule

// File: tb/tb_sign_ext_arbiter.sv
// Directed bench for sign_ext_arbiter (N=12, M=32): handshake, round-robin,
// stall, asynchronous reset and a full sweep of immediate values.

module tb_sign_ext_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req0_vld;
    logic [11:0] i_req0_imm;
    logic        o_req0_rdy;
    logic        i_req1_vld;
    logic [11:0] i_req1_imm;
    logic        o_req1_rdy;
    logic        o_out_vld;
    logic [31:0] o_out_imm;
    logic        o_out_src;
    logic        i_out_rdy;

    int checks = 0;
    int errors = 0;

    sign_ext_arbiter #(
        .N(12),
        .M(32)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_req0_vld(i_req0_vld),
        .i_req0_imm(i_req0_imm),
        .o_req0_rdy(o_req0_rdy),
        .i_req1_vld(i_req1_vld),
        .i_req1_imm(i_req1_imm),
        .o_req1_rdy(o_req1_rdy),
        .o_out_vld(o_out_vld),
        .o_out_imm(o_out_imm),
        .o_out_src(o_out_src),
        .i_out_rdy(i_out_rdy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] sweep_val;
        logic [31:0] sweep_exp;

        i_rst      = 1'b1;
        i_req0_vld = 1'b1;
        i_req0_imm = 12'h123;
        i_req1_vld = 1'b1;
        i_req1_imm = 12'h456;
        i_out_rdy  = 1'b1;
        step();
        step();
        check_output("rst_vld", o_out_vld, 32'd0);
        check_output("rst_imm", o_out_imm, 32'd0);
        check_output("rst_src", o_out_src, 32'd0);
        check_output("rst_rdy0", o_req0_rdy, 32'd0);
        check_output("rst_rdy1", o_req1_rdy, 32'd0);

        i_req0_vld = 1'b0;
        i_req1_vld = 1'b0;
        i_rst      = 1'b0;

        // Single requester 0, negative immediate
        i_req0_vld = 1'b1;
        i_req0_imm = 12'hFF6;
        #1;
        check_output("t1_rdy0", o_req0_rdy, 32'd1);
        check_output("t1_rdy1", o_req1_rdy, 32'd0);
        step();
        i_req0_vld = 1'b0;
        check_output("t1_vld", o_out_vld, 32'd1);
        check_output("t1_imm", o_out_imm, 32'hFFFF_FFF6);
        check_output("t1_src", o_out_src, 32'd0);
        step();
        check_output("t1_drop", o_out_vld, 32'd0);

        // Single requester 1, largest positive immediate
        i_req1_vld = 1'b1;
        i_req1_imm = 12'h7FF;
        #1;
        check_output("t2_rdy1", o_req1_rdy, 32'd1);
        check_output("t2_rdy0", o_req0_rdy, 32'd0);
        step();
        i_req1_vld = 1'b0;
        check_output("t2_imm", o_out_imm, 32'h0000_07FF);
        check_output("t2_src", o_out_src, 32'd1);
        step();
        check_output("t2_drop", o_out_vld, 32'd0);

        // Both requesting continuously: strict alternation starting at req0
        i_req0_vld = 1'b1;
        i_req0_imm = 12'h800;
        i_req1_vld = 1'b1;
        i_req1_imm = 12'h001;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_output("t3_rdy0", o_req0_rdy, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_output("t3_rdy1", o_req1_rdy, (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check_output("t3_vld", o_out_vld, 32'd1);
            check_output("t3_src", o_out_src, (k % 2 == 0) ? 32'd0 : 32'd1);
            check_output("t3_imm", o_out_imm, (k % 2 == 0) ? 32'hFFFF_F800 : 32'h0000_0001);
        end

        // Stall with slot FULL holding req1's result
        i_out_rdy = 1'b0;
        #1;
        check_output("t4_rdy0", o_req0_rdy, 32'd0);
        check_output("t4_rdy1", o_req1_rdy, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_output("t4_vld", o_out_vld, 32'd1);
            check_output("t4_src", o_out_src, 32'd1);
            check_output("t4_imm", o_out_imm, 32'h0000_0001);
            check_output("t4_stall_rdy0", o_req0_rdy, 32'd0);
        end
        i_out_rdy = 1'b1;
        #1;
        check_output("t4_rel_rdy0", o_req0_rdy, 32'd1);
        check_output("t4_rel_rdy1", o_req1_rdy, 32'd0);
        step();
        check_output("t4_rel_src", o_out_src, 32'd0);
        check_output("t4_rel_imm", o_out_imm, 32'hFFFF_F800);

        // Asynchronous reset between edges while pointer favours req1
        i_rst = 1'b1;
        #1;
        check_output("t5_vld", o_out_vld, 32'd0);
        check_output("t5_imm", o_out_imm, 32'd0);
        check_output("t5_src", o_out_src, 32'd0);
        check_output("t5_rdy0", o_req0_rdy, 32'd0);
        check_output("t5_rdy1", o_req1_rdy, 32'd0);
        step();
        i_rst = 1'b0;
        #1;
        check_output("t5_after_rdy0", o_req0_rdy, 32'd1);
        check_output("t5_after_rdy1", o_req1_rdy, 32'd0);
        step();
        check_output("t5_after_src", o_out_src, 32'd0);
        check_output("t5_after_imm", o_out_imm, 32'hFFFF_F800);

        // Requesters drop while consumer stalls: slot held, then drains
        i_req0_vld = 1'b0;
        i_req1_vld = 1'b0;
        i_out_rdy  = 1'b0;
        step();
        check_output("t5_hold_vld", o_out_vld, 32'd1);
        check_output("t5_hold_src", o_out_src, 32'd0);
        i_out_rdy = 1'b1;
        step();
        check_output("t5_drain_vld", o_out_vld, 32'd0);
        step();
        check_output("t5_idle_vld", o_out_vld, 32'd0);

        // Sweep every 12-bit immediate through requester 0
        i_req0_vld = 1'b1;
        for (int v = 0; v < 4096; v++) begin
            sweep_val  = v[11:0];
            sweep_exp  = {{20{sweep_val[11]}}, sweep_val};
            i_req0_imm = sweep_val;
            step();
            check_output("t6_sweep", o_out_imm, sweep_exp);
        end
        i_req0_vld = 1'b0;
        step();
        check_output("t6_end_vld", o_out_vld, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
